sys_time_sync: RTL and testbench

- Produces the free-running 64-bit SYS_TIME bus consumed by the update-timing and modulation/sequence timing blocks.
- Disciplines that bus to the EtherCAT distributed clock. On each SYNC0 edge it compares the local time with the host-supplied sync timestamp.
- Large errors are corrected by a hard load. Small errors are slewed out at ±1 tick per cycle, so downstream modulo-based timing never sees a jump.

---
 rtl/sys_time_pkg.sv | 28 ++
 rtl/sys_time_sync_edge_det.sv | 52 +++++
 rtl/sys_time_sync.sv | 191 +++++++++++++++++++
 tb/tb_sys_time_sync.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_time_pkg.sv
// Shared types and constants for the disciplined system-time block.
package sys_time_pkg;

  localparam int SYS_TIME_WIDTH = 64;
  localparam int APPLY_LATENCY  = 4;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CALC1,
    CALC2,
    APPLY,
    SLEW
  } state_t;

  // True when d, read as a 64-bit two's-complement value, fits in a w-bit signed field
  function automatic logic fits_signed(input logic [SYS_TIME_WIDTH-1:0] d, input int w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < SYS_TIME_WIDTH; i++) begin
      if ((i >= w) && (d[i] != d[w-1])) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/sys_time_sync_edge_det.sv
// SYNC0 synchronizer, rising-edge detector and holdoff counter.
// EDGE is a one-cycle pulse in the cycle where the synchronized edge is seen,
// suppressed unless at least SYNC_PERIOD_MIN cycles passed since the last accepted edge.
module sync0_edge_det
  import sys_time_pkg::*;
#(
  parameter int SYNC_PERIOD_MIN = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic SYNC0,
  output logic EDGE
);

  localparam int CW = (SYNC_PERIOD_MIN < 1) ? 1 : $clog2(SYNC_PERIOD_MIN + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(SYNC_PERIOD_MIN);
  localparam logic [CW-1:0] HOLD_ONE = CW'(1);

  logic          sync1;
  logic          sync2;
  logic          sync3;
  logic          raw_edge;
  logic [CW-1:0] holdoff;

  assign raw_edge = sync2 & ~sync3;
  assign EDGE     = raw_edge && (holdoff >= HOLD_MAX);

  // Two-flop synchronizer for the asynchronous pulse plus a delay stage for edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= SYNC0;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Holdoff counter: cleared by an accepted edge, otherwise counts up and saturates
  always_ff @(posedge CLK) begin
    if (RST) begin
      holdoff <= '0;
    end else if (EDGE) begin
      holdoff <= '0;
    end else if (holdoff != HOLD_MAX) begin
      holdoff <= holdoff + HOLD_ONE;
    end
  end

endmodule

// File: rtl/sys_time_sync.sv
// Free-running 64-bit system time disciplined to the EtherCAT distributed clock.
// Large errors are hard-loaded, small errors are slewed at one tick per cycle.
// Optional statistics (SYNC_ERR_MAX, JUMP_CNT, STAT_CLR) are built when the
// macro SYS_TIME_SYNC_STAT_EN is defined.
module sys_time_sync
  import sys_time_pkg::*;
#(
  parameter int DIFF_WIDTH      = 16,
  parameter int SYNC_PERIOD_MIN = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      SYNC0,
  input  logic [SYS_TIME_WIDTH-1:0] ECAT_SYNC_TIME,
  output logic [SYS_TIME_WIDTH-1:0] SYS_TIME,
  output logic                      SYNCED,
  output logic                      SLEWING
`ifdef SYS_TIME_SYNC_STAT_EN
  ,
  input  logic                      STAT_CLR,
  output logic [DIFF_WIDTH-1:0]     SYNC_ERR_MAX,
  output logic [15:0]               JUMP_CNT
`endif
);

  localparam int HALF = SYS_TIME_WIDTH / 2;
  localparam logic [SYS_TIME_WIDTH-1:0] TIME_ONE = SYS_TIME_WIDTH'(1);
  localparam logic [SYS_TIME_WIDTH-1:0] TIME_TWO = SYS_TIME_WIDTH'(2);
  localparam logic [SYS_TIME_WIDTH-1:0] TIME_LAT = SYS_TIME_WIDTH'(APPLY_LATENCY);
  localparam logic [DIFF_WIDTH-1:0]     RES_ONE  = {{(DIFF_WIDTH-1){1'b0}}, 1'b1};

  state_t                    state;
  state_t                    state_n;
  logic [SYS_TIME_WIDTH-1:0] sys_time;
  logic [SYS_TIME_WIDTH-1:0] sys_n;
  logic                      synced;
  logic                      synced_n;
  logic [DIFF_WIDTH-1:0]     residual;
  logic [DIFF_WIDTH-1:0]     res_n;
  logic                      slewing;
  logic                      edge_acc;
  logic                      cap_en;
  logic [SYS_TIME_WIDTH-1:0] cap_c;
  logic [SYS_TIME_WIDTH-1:0] cap_t;
  logic [HALF:0]             diff_lo;
  logic [HALF-1:0]           diff_hi;
  logic [SYS_TIME_WIDTH-1:0] diff;
  logic                      in_range;
  logic                      take_jump;
  logic                      res_pos;
  logic                      res_neg;

  sync0_edge_det #(
    .SYNC_PERIOD_MIN(SYNC_PERIOD_MIN)
  ) u_edge_det (
    .CLK  (CLK),
    .RST  (RST),
    .SYNC0(SYNC0),
    .EDGE (edge_acc)
  );

  assign diff      = {diff_hi, diff_lo[HALF-1:0]};
  assign in_range  = fits_signed(diff, DIFF_WIDTH);
  assign take_jump = !synced || !in_range;
  assign res_neg   = residual[DIFF_WIDTH-1];
  assign res_pos   = !residual[DIFF_WIDTH-1] && (residual != '0);

  assign SYS_TIME = sys_time;
  assign SYNCED   = synced;
  assign SLEWING  = slewing;

  // Next-state, next-time and residual decisions for the discipline FSM
  always_comb begin
    state_n  = state;
    sys_n    = sys_time + TIME_ONE;
    res_n    = residual;
    synced_n = synced;
    cap_en   = 1'b0;
    case (state)
      INIT, IDLE: begin
        if (edge_acc) begin
          cap_en  = 1'b1;
          state_n = CALC1;
        end
      end
      CALC1: state_n = CALC2;
      CALC2: state_n = APPLY;
      APPLY: begin
        if (take_jump) begin
          sys_n    = cap_t + TIME_LAT;
          res_n    = '0;
          synced_n = 1'b1;
          state_n  = IDLE;
        end else begin
          res_n   = diff[DIFF_WIDTH-1:0];
          state_n = (diff[DIFF_WIDTH-1:0] == '0) ? IDLE : SLEW;
        end
      end
      SLEW: begin
        if (edge_acc) begin
          cap_en  = 1'b1;
          res_n   = '0;
          state_n = CALC1;
        end else if (res_pos) begin
          sys_n = sys_time + TIME_TWO;
          res_n = residual - RES_ONE;
          if (residual == RES_ONE) begin
            state_n = IDLE;
          end
        end else if (res_neg) begin
          sys_n = sys_time;
          res_n = residual + RES_ONE;
          if (residual == '1) begin
            state_n = IDLE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = INIT;
    endcase
  end

  // Core state register: time, sync flag, residual and its registered non-zero flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= INIT;
      sys_time <= '0;
      synced   <= 1'b0;
      residual <= '0;
      slewing  <= 1'b0;
    end else begin
      state    <= state_n;
      sys_time <= sys_n;
      synced   <= synced_n;
      residual <= res_n;
      slewing  <= (res_n != '0);
    end
  end

  // Capture at the edge, then split the 64-bit T - C into low half with borrow and high half
  always_ff @(posedge CLK) begin
    if (RST) begin
      cap_c   <= '0;
      cap_t   <= '0;
      diff_lo <= '0;
      diff_hi <= '0;
    end else begin
      if (cap_en) begin
        cap_c <= sys_time;
        cap_t <= ECAT_SYNC_TIME;
      end
      if (state == CALC1) begin
        diff_lo <= {1'b0, cap_t[HALF-1:0]} - {1'b0, cap_c[HALF-1:0]};
      end
      if (state == CALC2) begin
        diff_hi <= cap_t[SYS_TIME_WIDTH-1:HALF] - cap_c[SYS_TIME_WIDTH-1:HALF]
                   - {{(HALF-1){1'b0}}, diff_lo[HALF]};
      end
    end
  end

`ifdef SYS_TIME_SYNC_STAT_EN
  logic [DIFF_WIDTH-1:0] d_low;
  logic [DIFF_WIDTH-1:0] abs_d;
  logic [DIFF_WIDTH-1:0] err_max;
  logic [15:0]           jump_cnt;

  assign d_low        = diff[DIFF_WIDTH-1:0];
  assign abs_d        = d_low[DIFF_WIDTH-1] ? (~d_low + RES_ONE) : d_low;
  assign SYNC_ERR_MAX = err_max;
  assign JUMP_CNT     = jump_cnt;

  // Track the worst slew-path error and count re-jumps once already synced
  always_ff @(posedge CLK) begin
    if (RST || STAT_CLR) begin
      err_max  <= '0;
      jump_cnt <= '0;
    end else if (state == APPLY) begin
      if (take_jump) begin
        if (synced && (jump_cnt != 16'hFFFF)) begin
          jump_cnt <= jump_cnt + 16'd1;
        end
      end else if (abs_d > err_max) begin
        err_max <= abs_d;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sys_time_sync.sv
// Scoreboard bench for sys_time_sync: stimulus pushes expected samples keyed by
// clock tick, a negedge monitor pops and compares them.
module tb_sys_time_sync;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SYNC0;
  logic [63:0] ECAT_SYNC_TIME;
  logic [63:0] SYS_TIME;
  logic        SYNCED;
  logic        SLEWING;
`ifdef SYS_TIME_SYNC_STAT_EN
  logic        STAT_CLR;
  logic [15:0] SYNC_ERR_MAX;
  logic [15:0] JUMP_CNT;
`endif

  sys_time_sync dut (
    .CLK           (CLK),
    .RST           (RST),
    .SYNC0         (SYNC0),
    .ECAT_SYNC_TIME(ECAT_SYNC_TIME),
    .SYS_TIME      (SYS_TIME),
    .SYNCED        (SYNCED),
    .SLEWING       (SLEWING)
`ifdef SYS_TIME_SYNC_STAT_EN
    ,
    .STAT_CLR      (STAT_CLR),
    .SYNC_ERR_MAX  (SYNC_ERR_MAX),
    .JUMP_CNT      (JUMP_CNT)
`endif
  );

  typedef struct {
    int          at;
    logic [63:0] t;
    logic        syn;
    logic        slw;
    logic        stat;
    logic [15:0] jc;
    logic [15:0] em;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          tick = 0;
  logic [63:0] off;

  always #5 CLK = ~CLK;

  // Free-running tick count used to schedule expected samples
  always @(posedge CLK) tick <= tick + 1;

  function automatic void pushExpect(input int at, input logic [63:0] t, input logic syn,
                                     input logic slw, input logic stat = 1'b0,
                                     input logic [15:0] jc = 16'd0, input logic [15:0] em = 16'd0);
    exp_t e;
    e.at = at; e.t = t; e.syn = syn; e.slw = slw; e.stat = stat; e.jc = jc; e.em = em;
    sb.push_back(e);
  endfunction

  function automatic logic [63:0] sysAt(input int n);
    return 64'(n) + off;
  endfunction

  task automatic waitUntil(input int n);
    while (tick < n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drive ECAT_SYNC_TIME and a one-cycle SYNC0 pulse so the synchronized edge lands on tick e
  task automatic applyStimulus(input int e, input logic [63:0] t);
    waitUntil(e - 2);
    ECAT_SYNC_TIME = t;
    SYNC0 = 1'b1;
    waitUntil(e - 1);
    SYNC0 = 1'b0;
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (SYS_TIME !== e.t || SYNCED !== e.syn || SLEWING !== e.slw) begin
      errors++;
      $display("[TB] FAIL core@%0d: got time=%0d synced=%0b slewing=%0b, want time=%0d synced=%0b slewing=%0b",
               e.at, SYS_TIME, SYNCED, SLEWING, e.t, e.syn, e.slw);
    end
`ifdef SYS_TIME_SYNC_STAT_EN
    if (e.stat) begin
      checks++;
      if (JUMP_CNT !== e.jc || SYNC_ERR_MAX !== e.em) begin
        errors++;
        $display("[TB] FAIL stat@%0d: got jump_cnt=%0d err_max=%0d, want jump_cnt=%0d err_max=%0d",
                 e.at, JUMP_CNT, SYNC_ERR_MAX, e.jc, e.em);
      end
    end
`endif
  endtask

  // Monitor: pop every expectation scheduled for this tick and compare away from the edge
  always @(negedge CLK) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= tick) begin
      e = sb.pop_front();
      if (e.at < tick) begin
        checks++;
        errors++;
        $display("[TB] FAIL missed@%0d: sample not taken, now tick %0d", e.at, tick);
      end else begin
        checkOutput(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, tick %0d", tick);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    int base, e1, e2, e3, e4, e5, e6, e7, e8;
    logic [63:0] c, t, c5, t5, c6, t6;

    RST = 1'b1;
    SYNC0 = 1'b0;
    ECAT_SYNC_TIME = '0;
`ifdef SYS_TIME_SYNC_STAT_EN
    STAT_CLR = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    base = tick;
    $display("[TB] reset released at tick %0d", base);

    // Free running before the first sync
    pushExpect(base, 64'd0, 1'b0, 1'b0);
    pushExpect(base + 100, 64'd100, 1'b0, 1'b0);

    // First edge at SYS_TIME=500 with T=10000: unconditional hard load
    e1 = base + 500;
    pushExpect(e1, 64'd500, 1'b0, 1'b0);
    pushExpect(e1 + 3, 64'd503, 1'b0, 1'b0);
    pushExpect(e1 + 4, 64'd10004, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
    pushExpect(e1 + 10, 64'd10010, 1'b1, 1'b0);
    applyStimulus(e1, 64'd10000);
    off = 64'd10000 - 64'(e1);

    // D=+3: three cycles of +2, then normal counting
    e2 = e1 + 50;
    c = sysAt(e2);
    t = c + 64'd3;
    pushExpect(e2 + 3, t, 1'b1, 1'b0);
    pushExpect(e2 + 4, t + 64'd1, 1'b1, 1'b1);
    pushExpect(e2 + 5, t + 64'd3, 1'b1, 1'b1);
    pushExpect(e2 + 6, t + 64'd5, 1'b1, 1'b1);
    pushExpect(e2 + 7, t + 64'd7, 1'b1, 1'b0);
    pushExpect(e2 + 12, t + 64'd12, 1'b1, 1'b0, 1'b1, 16'd0, 16'd3);
    applyStimulus(e2, t);
    off = t - 64'(e2);

    // D=-5: five stalled cycles, never a decrement
    e3 = e2 + 50;
    c = sysAt(e3);
    t = c - 64'd5;
    pushExpect(e3 + 4, t + 64'd9, 1'b1, 1'b1);
    pushExpect(e3 + 6, t + 64'd9, 1'b1, 1'b1);
    pushExpect(e3 + 8, t + 64'd9, 1'b1, 1'b1);
    pushExpect(e3 + 9, t + 64'd9, 1'b1, 1'b0);
    pushExpect(e3 + 10, t + 64'd10, 1'b1, 1'b0, 1'b1, 16'd0, 16'd5);
    applyStimulus(e3, t);
    off = t - 64'(e3);

    // D=+40000 is outside a 16-bit residual: hard load, no slewing
    e4 = e3 + 50;
    c = sysAt(e4);
    t = c + 64'd40000;
    pushExpect(e4 + 3, c + 64'd3, 1'b1, 1'b0);
    pushExpect(e4 + 4, t + 64'd4, 1'b1, 1'b0, 1'b1, 16'd1, 16'd5);
    pushExpect(e4 + 5, t + 64'd5, 1'b1, 1'b0);
    applyStimulus(e4, t);
    off = t - 64'(e4);

    // Residual 20 interrupted by a new edge ten cycles later with D=+2
    e5 = e4 + 50;
    e6 = e5 + 10;
    c5 = sysAt(e5);
    t5 = c5 + 64'd20;
    c6 = c5 + 64'd16;
    t6 = c6 + 64'd2;
    pushExpect(e5 + 4, c5 + 64'd4, 1'b1, 1'b1, 1'b1, 16'd1, 16'd20);
    pushExpect(e6, c6, 1'b1, 1'b1);
    pushExpect(e6 + 1, c6 + 64'd1, 1'b1, 1'b0);
    pushExpect(e6 + 4, t6 + 64'd2, 1'b1, 1'b1);
    pushExpect(e6 + 6, t6 + 64'd6, 1'b1, 1'b0);
    pushExpect(e6 + 7, t6 + 64'd7, 1'b1, 1'b0);
    applyStimulus(e5, t5);
    applyStimulus(e6, t6);
    off = t6 - 64'(e6);

    // D=0 followed by edges 3 and 6 cycles later, both inside the holdoff window
    e7 = e6 + 50;
    t = sysAt(e7);
    pushExpect(e7 + 4, t + 64'd4, 1'b1, 1'b0);
    pushExpect(e7 + 10, t + 64'd10, 1'b1, 1'b0);
    pushExpect(e7 + 14, t + 64'd14, 1'b1, 1'b0);
`ifdef SYS_TIME_SYNC_STAT_EN
    pushExpect(e7 + 22, t + 64'd22, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
`endif
    applyStimulus(e7, t);
    applyStimulus(e7 + 3, t);
    applyStimulus(e7 + 6, t);
`ifdef SYS_TIME_SYNC_STAT_EN
    waitUntil(e7 + 20);
    STAT_CLR = 1'b1;
    waitUntil(e7 + 21);
    STAT_CLR = 1'b0;
`endif
    off = t - 64'(e7);

    // Reset asserted during CALC2 discards the pending capture
    e8 = e7 + 50;
    c = sysAt(e8);
    t = c + 64'd100;
    pushExpect(e8 + 2, c + 64'd2, 1'b1, 1'b0);
    pushExpect(e8 + 3, 64'd0, 1'b0, 1'b0);
    pushExpect(e8 + 23, 64'd20, 1'b0, 1'b0);
    applyStimulus(e8, t);
    waitUntil(e8 + 2);
    RST = 1'b1;
    waitUntil(e8 + 3);
    RST = 1'b0;

    waitUntil(e8 + 30);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL leftover: %0d samples never compared, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
